// File: rtl/rip_axi_master_if.sv
// Shared constants and the AXI4 full bus bundle used by the rip_axi master.
package rip_const;
    parameter int B_WIDTH = 8;
endpackage

interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/rip_axi_master.sv
// Simple AXI4 burst master: one fixed-length INCR write engine and one read engine, running independently.
//
// state  | meaning
// W_IDLE | write engine free, wready high
// W_ADDR | AW channel presented, waiting for awready
// W_DATA | streaming captured words, lowest first
// W_RESP | waiting for write response
// R_IDLE | read engine free, rready high
// R_ADDR | AR channel presented, waiting for arready
// R_DATA | collecting read beats into rdata
module rip_axi_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 2,
    parameter int B_WIDTH    = rip_const::B_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    output logic                                   wready,
    input  logic [ADDR_WIDTH-1:0]                  waddr,
    input  logic [DATA_WIDTH*BURST_LEN-1:0]        wdata,
    input  logic [DATA_WIDTH*BURST_LEN/B_WIDTH-1:0] wstrb,
    input  logic                                   wvalid,
    output logic                                   wdone,
    output logic                                   rready,
    input  logic [ADDR_WIDTH-1:0]                  raddr,
    input  logic                                   rvalid,
    output logic [DATA_WIDTH*BURST_LEN-1:0]        rdata,
    output logic                                   rdone,
    rip_axi_interface.master                       M_AXI
);

    localparam int STRB_BEAT = DATA_WIDTH / B_WIDTH;
    localparam int STRB_ALL  = DATA_WIDTH * BURST_LEN / B_WIDTH;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0] AX_LEN  = 8'(BURST_LEN - 1);
    localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0]                     w_state;
    logic [ADDR_WIDTH-1:0]          w_addr_q;
    logic [DATA_WIDTH*BURST_LEN-1:0] w_data_q;
    logic [STRB_ALL-1:0]            w_strb_q;
    logic [BEAT_W-1:0]              w_beat;
    logic                           wdone_q;

    logic [1:0]                     r_state;
    logic [ADDR_WIDTH-1:0]          r_addr_q;
    logic [DATA_WIDTH*BURST_LEN-1:0] rdata_q;
    logic [BEAT_W-1:0]              r_beat;
    logic                           rdone_q;

    // The captured payload is shifted down one word per accepted beat, so the
    // current beat is always in the low slice.
    always_ff @(posedge clk) begin
        if (rstn) begin
            w_state  <= W_IDLE;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            w_beat   <= '0;
            wdone_q  <= 1'b0;
        end else begin
            wdone_q <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (wvalid) begin
                        w_addr_q <= waddr;
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        w_beat   <= '0;
                        w_state  <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (M_AXI.awready) begin
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (M_AXI.wready) begin
                        w_data_q <= w_data_q >> DATA_WIDTH;
                        w_strb_q <= w_strb_q >> STRB_BEAT;
                        w_beat   <= w_beat + 1'b1;
                        if (w_beat == LAST_BEAT) begin
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (M_AXI.bvalid) begin
                        w_state <= W_IDLE;
                        wdone_q <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign wready = (w_state == W_IDLE);
    assign wdone  = wdone_q;

    assign M_AXI.awid     = '0;
    assign M_AXI.awaddr   = w_addr_q;
    assign M_AXI.awlen    = AX_LEN;
    assign M_AXI.awsize   = AX_SIZE;
    assign M_AXI.awburst  = 2'b01;
    assign M_AXI.awlock   = 1'b0;
    assign M_AXI.awcache  = 4'd0;
    assign M_AXI.awprot   = 3'd0;
    assign M_AXI.awqos    = 4'd0;
    assign M_AXI.awregion = 4'd0;
    assign M_AXI.awvalid  = (w_state == W_ADDR);

    assign M_AXI.wdata  = w_data_q[DATA_WIDTH-1:0];
    assign M_AXI.wstrb  = w_strb_q[STRB_BEAT-1:0];
    assign M_AXI.wlast  = (w_state == W_DATA) && (w_beat == LAST_BEAT);
    assign M_AXI.wvalid = (w_state == W_DATA);
    assign M_AXI.bready = (w_state == W_RESP);

    // A short burst terminated by RLAST still completes the read cleanly.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state  <= R_IDLE;
            r_addr_q <= '0;
            rdata_q  <= '0;
            r_beat   <= '0;
            rdone_q  <= 1'b0;
        end else begin
            rdone_q <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (rvalid) begin
                        r_addr_q <= raddr;
                        r_beat   <= '0;
                        r_state  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (M_AXI.arready) begin
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (M_AXI.rvalid) begin
                        for (int i = 0; i < BURST_LEN; i++) begin
                            if (r_beat == BEAT_W'(i)) begin
                                rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= M_AXI.rdata;
                            end
                        end
                        r_beat <= r_beat + 1'b1;
                        if (M_AXI.rlast || (r_beat == LAST_BEAT)) begin
                            r_state <= R_IDLE;
                            rdone_q <= 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign rready = (r_state == R_IDLE);
    assign rdone  = rdone_q;
    assign rdata  = rdata_q;

    assign M_AXI.arid     = '0;
    assign M_AXI.araddr   = r_addr_q;
    assign M_AXI.arlen    = AX_LEN;
    assign M_AXI.arsize   = AX_SIZE;
    assign M_AXI.arburst  = 2'b01;
    assign M_AXI.arlock   = 1'b0;
    assign M_AXI.arcache  = 4'd0;
    assign M_AXI.arprot   = 3'd0;
    assign M_AXI.arqos    = 4'd0;
    assign M_AXI.arregion = 4'd0;
    assign M_AXI.arvalid  = (r_state == R_ADDR);
    assign M_AXI.rready   = (r_state == R_DATA);

endmodule

// File: tb/tb_rip_axi_master.sv
// Bench for rip_axi_master: randomized-ready AXI slave memory plus a byte-array reference model.
module tb_rip_axi_master;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BL  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic [63:0]   wdata = '0;
    logic [7:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic          rvalid = 1'b0;
    logic          wready, wdone, rready, rdone;
    logic [63:0]   rdata;

    always #5 clk = ~clk;

    rip_axi_interface #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    rip_axi_master #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn),
        .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wdone(wdone),
        .rready(rready), .raddr(raddr), .rvalid(rvalid), .rdata(rdata), .rdone(rdone),
        .M_AXI(axi)
    );

    int errors = 0;
    int checks = 0;
    int aw_count = 0, ar_count = 0, wdone_count = 0, rdone_count = 0, exp_wdone = 0;
    logic [AW-1:0] exp_awaddr = '0, exp_araddr = '0;
    logic [7:0] slv_mem [0:255];
    logic [7:0] ref_mem [0:255];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [31:0] addr);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[8'(addr[7:0] + i)];
        return r;
    endfunction

    // Write-side slave: AW, W, B with random ready/valid timing.
    initial begin
        bit aw_have, need_b, b_fire;
        logic [7:0] a;
        int beat;
        aw_have = 0; need_b = 0; b_fire = 0; a = '0; beat = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        forever begin
            @(negedge clk); #1;
            if (wdone) wdone_count++;
            if (rstn) begin
                aw_have = 0; need_b = 0; b_fire = 0; beat = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            end else begin
                if (b_fire || wdone) check_val("wdone_timing", 64'(wdone), 64'(b_fire));
                if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
                if (need_b && !axi.bvalid && ($urandom_range(0, 1) == 1)) begin
                    axi.bvalid = 1;
                    axi.bresp  = 2'($urandom_range(0, 3));
                    axi.bid    = 4'($urandom_range(0, 15));
                end
                if (axi.bvalid && axi.bready) begin b_fire = 1; need_b = 0; end
                axi.awready = !aw_have && ($urandom_range(0, 2) != 0);
                if (axi.awvalid && axi.awready) begin
                    aw_have = 1; a = axi.awaddr[7:0]; beat = 0; aw_count++;
                    check_val("awaddr", 64'(axi.awaddr), 64'(exp_awaddr));
                    check_val("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst},
                              {4'd0, 8'd1, 3'd2, 2'b01});
                    check_val("aw_zero", {axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion}, 0);
                end
                axi.wready = aw_have && !need_b && ($urandom_range(0, 2) != 0);
                if (axi.wvalid && axi.wready) begin
                    for (int b = 0; b < 4; b++)
                        if (axi.wstrb[b]) slv_mem[8'(a + beat*4 + b)] = axi.wdata[8*b +: 8];
                    check_val("wlast", 64'(axi.wlast), 64'(beat == BL-1));
                    beat++;
                    if (beat == BL) begin aw_have = 0; need_b = 1; end
                end
            end
        end
    end

    // Read-side slave: AR and R with random timing; data comes from slv_mem.
    initial begin
        bit ar_have, r_fire, r_last_fire;
        logic [7:0] a;
        int beat;
        ar_have = 0; r_fire = 0; r_last_fire = 0; a = '0; beat = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rlast = 0; axi.rresp = 0; axi.rid = 0;
        forever begin
            @(negedge clk); #1;
            if (rdone) rdone_count++;
            if (rstn) begin
                ar_have = 0; r_fire = 0; r_last_fire = 0; beat = 0;
                axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
            end else begin
                if (r_last_fire || rdone) check_val("rdone_timing", 64'(rdone), 64'(r_last_fire));
                r_last_fire = 0;
                if (r_fire) begin
                    axi.rvalid = 0; r_fire = 0; beat++;
                    if (beat == BL) ar_have = 0;
                end
                if (ar_have && !axi.rvalid && ($urandom_range(0, 1) == 1)) begin
                    axi.rvalid = 1;
                    for (int b = 0; b < 4; b++) axi.rdata[8*b +: 8] = slv_mem[8'(a + beat*4 + b)];
                    axi.rlast = (beat == BL-1);
                    axi.rresp = 2'($urandom_range(0, 3));
                    axi.rid   = 4'($urandom_range(0, 15));
                end
                if (axi.rvalid && axi.rready) begin
                    r_fire = 1;
                    if (axi.rlast) r_last_fire = 1;
                end
                axi.arready = !ar_have && ($urandom_range(0, 2) != 0);
                if (axi.arvalid && axi.arready) begin
                    ar_have = 1; a = axi.araddr[7:0]; beat = 0; ar_count++;
                    check_val("araddr", 64'(axi.araddr), 64'(exp_araddr));
                    check_val("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
                              {4'd0, 8'd1, 3'd2, 2'b01});
                end
            end
        end
    end

    task automatic issue_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int n = 0;
        @(negedge clk);
        while (!wready && n < 300) begin @(negedge clk); n++; end
        if (!wready) check_val("wready_timeout", 0, 1);
        waddr = addr; wdata = data; wstrb = strb; wvalid = 1; exp_awaddr = addr;
        for (int i = 0; i < 8; i++) if (strb[i]) ref_mem[8'(addr[7:0] + i)] = data[8*i +: 8];
        @(negedge clk);
        wvalid = 0;
        check_val("aw_latency", 64'(axi.awvalid), 1);
        check_val("wready_busy", 64'(wready), 0);
    endtask

    task automatic wait_wdone();
        int n = 0;
        while (!wdone && n < 300) begin @(negedge clk); n++; end
        check_val("wdone_seen", 64'(wdone), 1);
        exp_wdone++;
    endtask

    task automatic issue_read(input logic [31:0] addr);
        int n = 0;
        @(negedge clk);
        while (!rready && n < 300) begin @(negedge clk); n++; end
        if (!rready) check_val("rready_timeout", 0, 1);
        raddr = addr; rvalid = 1; exp_araddr = addr;
        @(negedge clk);
        rvalid = 0;
        check_val("ar_latency", 64'(axi.arvalid), 1);
        check_val("rready_busy", 64'(rready), 0);
    endtask

    task automatic wait_rdone(input logic [63:0] exp, input logic [63:0] mask);
        int n = 0;
        while (!rdone && n < 300) begin @(negedge clk); n++; end
        check_val("rdone_seen", 64'(rdone), 1);
        check_val("rdata", rdata & mask, exp & mask);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        issue_write(addr, data, strb);
        wait_wdone();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [63:0] exp, input logic [63:0] mask);
        issue_read(addr);
        wait_rdone(exp, mask);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] ALL = 64'hffff_ffff_ffff_ffff;

    initial begin
        int w0, c0, n;
        logic [63:0] hold;
        for (int i = 0; i < 256; i++) begin slv_mem[i] = 8'h00; ref_mem[i] = 8'h00; end

        repeat (3) @(negedge clk);
        check_val("rst_ready", {62'd0, wready, rready}, 64'd3);
        check_val("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check_val("rst_done", {wdone, rdone}, 0);
        check_val("rst_rdata", rdata, 0);
        rstn = 0;
        repeat (2) @(negedge clk);

        do_write(32'h10, 64'h1234, 8'hff);
        do_read(32'h10, 64'h0000_0000_0000_1234, ALL);
        repeat (3) @(negedge clk);
        check_val("first_done_counts", {32'(wdone_count), 32'(rdone_count)}, {32'd1, 32'd1});

        do_write(32'h10, 64'h1234_5678_90ab_cdef, 8'hff);
        do_write(32'h18, 64'hcdef_90ab_5678_1234, 8'hff);
        do_read(32'h14, 64'h5678_1234_1234_5678, ALL);
        do_read(32'h1c, 64'h0000_0000_cdef_90ab, 64'h0000_0000_ffff_ffff);
        hold = rdata;
        repeat (5) @(negedge clk);
        check_val("rdata_hold", rdata, hold);

        do_write(32'h20, 64'hcafe_cafe_cafe_cafe, 8'hff);
        do_write(32'h28, 64'hbeaf_beaf_beaf_beaf, 8'hff);
        do_write(32'h20, 64'hbeef_beef_beef_beef, 8'b0110_0100);
        do_read(32'h20, 64'hcaef_befe_caef_cafe, ALL);
        do_read(32'h24, 64'hbeaf_beaf_caef_befe, ALL);

        do_write(32'h30, 64'hc0ff_eead_d1c0_ffee, 8'hff);
        fork
            issue_write(32'h38, 64'h0fab_1e55, 8'hff);
            issue_read(32'h30);
        join
        fork
            wait_wdone();
            wait_rdone(64'hc0ff_eead_d1c0_ffee, ALL);
        join
        do_read(32'h38, 64'h0000_0000_0fab_1e55, ALL);

        // Request while busy must be dropped.
        c0 = aw_count; w0 = wdone_count;
        issue_write(32'h40, 64'h1111_2222_3333_4444, 8'hff);
        waddr = 32'h80; wdata = 64'hdead_beef_dead_beef; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        wait_wdone();
        repeat (20) @(negedge clk);
        check_val("busy_aw_count", 64'(aw_count), 64'(c0 + 1));
        check_val("busy_wdone_count", 64'(wdone_count), 64'(w0 + 1));
        do_read(32'h80, 64'd0, ALL);
        do_read(32'h40, 64'h1111_2222_3333_4444, ALL);

        // Reset in the middle of the data phase.
        issue_write(32'h90, 64'h5555_6666_7777_8888, 8'hff);
        n = 0;
        while (!axi.wvalid && n < 300) begin @(negedge clk); n++; end
        check_val("reached_wdata", 64'(axi.wvalid), 1);
        w0 = wdone_count;
        rstn = 1;
        @(negedge clk);
        check_val("abort_wvalid", 64'(axi.wvalid), 0);
        check_val("abort_chan", {axi.awvalid, axi.bready, axi.arvalid, axi.rready, wdone, rdone}, 0);
        check_val("abort_rdata", rdata, 0);
        @(negedge clk);
        rstn = 0;
        repeat (10) @(negedge clk);
        check_val("abort_wready", 64'(wready), 1);
        check_val("abort_no_wdone", 64'(wdone_count), 64'(w0));
        exp_wdone = wdone_count;

        do_write(32'h98, 64'h0123_4567_89ab_cdef, 8'hff);
        do_read(32'h98, 64'h0123_4567_89ab_cdef, ALL);

        for (int k = 0; k < 30; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'(8 * $urandom_range(8, 15));
                do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            end else begin
                a = 32'(4 * $urandom_range(16, 30));
                do_read(a, model_read(a), ALL);
            end
        end
        repeat (5) @(negedge clk);
        check_val("total_wdone", 64'(wdone_count), 64'(exp_wdone));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
